// File: rtl/alu_ops_pkg.sv
// Shared ALUOperation encodings, FSM state type and datapath width defaults
// for the execute-stage ALU and the ALU control decoder.
package alu_ops_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_SRL     = 4'b0101;
    localparam logic [3:0] OP_SLL     = 4'b0110;
    localparam logic [3:0] OP_DEFAULT = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL);
    endfunction

endpackage

// File: rtl/iter_shifter.sv
// One-bit-per-cycle shifter: latches operand, amount and direction on load_i,
// then shifts while run_i is high and raises finish_o once the count is spent.
module iter_shifter
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             load_left_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic [SHW-1:0]   load_amt_i,
    input  logic             run_i,
    output logic [WIDTH-1:0] data_o,
    output logic             finish_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;

    // NOTE: every variable gets a default before the branches so an
    // unassigned path cannot infer a latch.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        left_d = left_q;
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = load_amt_i;
            left_d = load_left_i;
        end else if (run_i && (cnt_q != '0)) begin
            data_d = left_q ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
            cnt_d  = cnt_q - SHW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together on the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            left_q <= left_d;
        end
    end

    assign data_o   = data_q;
    assign finish_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle logic/add/sub, iterative shifts with a
// busy/done handshake, and registered result, zero and illegal flags.
module seq_alu
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             accepting;
    logic             shift_load;
    logic [WIDTH-1:0] sh_data;
    logic             sh_finish;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (ALUOperation)
            OP_AND:         alu_res = A & B;
            OP_OR:          alu_res = A | B;
            OP_NOR:         alu_res = ~(A | B);
            OP_ADD:         alu_res = A + B;
            OP_SUB:         alu_res = A - B;
            OP_SRL, OP_SLL: alu_res = '0;
            default:        alu_ill = 1'b1;
        endcase
    end

    assign accepting  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign shift_load = accepting && start && is_shift(ALUOperation);

    iter_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (shift_load),
        .load_left_i (ALUOperation == OP_SLL),
        .load_data_i (B),
        .load_amt_i  (shamt),
        .run_i       (state_q == ST_SHIFT),
        .data_o      (sh_data),
        .finish_o    (sh_finish)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (is_shift(ALUOperation)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_ill;
                        state_d   = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sh_finish) begin
                    result_d  = sh_data;
                    zero_d    = (sh_data == '0);
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Handshake outputs decode registered state only, so no input reaches them combinationally.
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  ALUOperation = 4'b0000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, Zero, illegal;
    logic [31:0] ALUResult;

    int checks = 0;
    int errors = 0;

    seq_alu dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .shamt        (shamt),
        .busy         (busy),
        .done         (done),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: result from the operation definitions, latency from the timing rules.
    task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, output logic [31:0] res, output logic ill,
                           output int lat);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0: res = a & b;
            4'd1: res = a | b;
            4'd2: res = ~(a | b);
            4'd3: res = a + b;
            4'd4: res = a - b;
            4'd5: begin res = b >> sh; lat = int'(sh) + 2; end
            4'd6: begin res = b << sh; lat = int'(sh) + 2; end
            default: begin res = 32'd0; ill = 1'b1; end
        endcase
    endtask

    // Issues one op, scrambles the operands after the accept edge, and waits
    // (bounded) for done. lat counts negedges after the accept edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; shamt = 5'($urandom);
        ALUOperation = 4'($urandom);
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, illegal, Zero} !== 4'b0001 || ALUResult !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: busy/done/illegal/Zero=%b result=%h, need 0001 result=0",
                     {busy, done, illegal, Zero}, ALUResult);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_release: done=%b busy=%b, need 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_shift;
        int lat, bc, done_cnt, busy_cnt;
        run_op(4'd3, 32'h10, 32'h20, 5'd0, lat, bc);
        checks++;
        if (ALUResult !== 32'h30 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_add: result=%h Zero=%b, need 00000030 0", ALUResult, Zero);
        end
        @(negedge clk);
        start = 1'b1; ALUOperation = 4'd6; B = 32'h3; shamt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift_busy: busy=%b, need 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, illegal, Zero} !== 4'b0001 || ALUResult !== 32'd0) begin
            errors++;
            $display("FAIL mid_shift_reset: busy/done/illegal/Zero=%b result=%h, need 0001 result=0",
                     {busy, done, illegal, Zero}, ALUResult);
        end
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        checks++;
        if (done_cnt != 0 || busy_cnt != 0 || ALUResult !== 32'd0) begin
            errors++;
            $display("FAIL abandoned_shift: done=%0d busy=%0d result=%h, need 0 0 0",
                     done_cnt, busy_cnt, ALUResult);
        end
    endtask

    task automatic test_add_sub;
        int lat, bc;
        run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, bc);
        checks++;
        if (lat != 1 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: lat=%0d result=%h Zero=%b, need 1 00000000 1", lat, ALUResult, Zero);
        end
        run_op(4'd4, 32'd5, 32'd7, 5'd0, lat, bc);
        checks++;
        if (lat != 1 || ALUResult !== 32'hFFFF_FFFE || Zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap: lat=%0d result=%h Zero=%b, need 1 fffffffe 0", lat, ALUResult, Zero);
        end
    endtask

    task automatic test_shifts;
        int lat, bc;
        run_op(4'd6, 32'h1, 32'h1, 5'd31, lat, bc);
        checks++;
        if (lat != 33 || bc != 32 || ALUResult !== 32'h8000_0000 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL sll_31: lat=%0d busy=%0d result=%h Zero=%b, need 33 32 80000000 0",
                     lat, bc, ALUResult, Zero);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ALUResult !== 32'h8000_0000) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b result=%h, need 0 80000000", done, ALUResult);
        end
        run_op(4'd5, 32'h0, 32'h8000_0000, 5'd0, lat, bc);
        checks++;
        if (lat != 2 || bc != 1 || ALUResult !== 32'h8000_0000) begin
            errors++;
            $display("FAIL srl_0: lat=%0d busy=%0d result=%h, need 2 1 80000000", lat, bc, ALUResult);
        end
    endtask

    task automatic test_start_during_shift;
        int done_cnt, first;
        logic [31:0] res;
        done_cnt = 0;
        first = 0;
        res = '0;
        @(negedge clk);
        start = 1'b1; ALUOperation = 4'd5; A = 32'hDEAD_BEEF; B = 32'h1234_5678; shamt = 5'd4;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b0; B = 32'hFFFF_0000; end
            if (i == 2) begin start = 1'b1; ALUOperation = 4'd3; A = 32'd1; B = 32'd2; end
            if (i == 3) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (first == 0) begin first = i; res = ALUResult; end
            end
        end
        checks++;
        if (done_cnt != 1 || first != 6 || res !== 32'h0123_4567) begin
            errors++;
            $display("FAIL start_in_shift: dones=%0d lat=%0d result=%h, need 1 6 01234567",
                     done_cnt, first, res);
        end
        checks++;
        if (ALUResult !== 32'h0123_4567) begin
            errors++;
            $display("FAIL start_in_shift_hold: result=%h, need 01234567", ALUResult);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops  [3] = '{4'd1, 4'd2, 4'd0};
        logic [31:0] exps [3] = '{32'hFFFF_FFFF, 32'h0, 32'h0};
        @(negedge clk);
        A = 32'hF0F0_F0F0; B = 32'h0F0F_0F0F; start = 1'b1; ALUOperation = ops[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || ALUResult !== exps[i] || Zero !== (exps[i] == 32'h0)) begin
                errors++;
                $display("FAIL back_to_back_%0d: done=%b result=%h Zero=%b, need 1 %h %b",
                         i, done, ALUResult, Zero, exps[i], exps[i] == 32'h0);
            end
            if (i < 2) ALUOperation = ops[i+1];
            else start = 1'b0;
        end
    endtask

    task automatic test_illegal;
        int lat, bc;
        run_op(4'b1001, 32'h1234, 32'h5678, 5'd3, lat, bc);
        checks++;
        if (lat != 1 || illegal !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: lat=%0d illegal=%b result=%h Zero=%b, need 1 1 0 1",
                     lat, illegal, ALUResult, Zero);
        end
        run_op(4'd3, 32'd3, 32'd4, 5'd0, lat, bc);
        checks++;
        if (illegal !== 1'b0 || ALUResult !== 32'd7 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: illegal=%b result=%h Zero=%b, need 0 7 0",
                     illegal, ALUResult, Zero);
        end
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [31:0] a, b, exp_res;
        logic [4:0]  sh;
        logic        exp_ill;
        int          exp_lat, lat, bc;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            a  = $urandom;
            b  = (n % 8 == 7) ? a : $urandom;
            sh = 5'($urandom);
            ref_alu(op, a, b, sh, exp_res, exp_ill, exp_lat);
            run_op(op, a, b, sh, lat, bc);
            checks++;
            if (ALUResult !== exp_res || Zero !== (exp_res == 32'd0) || illegal !== exp_ill
                || lat != exp_lat || bc != exp_lat - 1) begin
                errors++;
                $display("FAIL random_%0d op=%h a=%h b=%h sh=%0d: result=%h Zero=%b ill=%b lat=%0d busy=%0d, need %h %b %b %0d %0d",
                         n, op, a, b, sh, ALUResult, Zero, illegal, lat, bc,
                         exp_res, exp_res == 32'd0, exp_ill, exp_lat, exp_lat - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shifts();
        test_start_during_shift();
        test_back_to_back();
        test_illegal();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Execute-stage ALU that consumes the 4-bit `ALUOperation` code produced by the ALU control decoder and the two register operands. It returns a registered 32-bit result and zero flag. Logic and add/sub complete in one cycle; shifts run iteratively, one bit per cycle, with a busy/done handshake so the datapath controller can stall the PC while a shift is in flight.

## Interface
- `WIDTH`, 32: operand/result width.
- `SHW`, 5: shift-amount width, equal to log2(WIDTH).
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-high; one clock domain.
- `start` input, 1 bit: request; sampled only when accepting (state IDLE or DONE).
- `ALUOperation` input, 4 bits: 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB, 0101 SRL, 0110 SLL; any other code is illegal (1001 is the decoder default).
- `A` input, WIDTH bits: rs operand.
- `B` input, WIDTH bits: rt operand; this is the shifted operand for SRL/SLL.
- `shamt` input, SHW bits: shift amount, instruction bits [10:6].
- `busy` output, 1 bit: high while state is SHIFT.
- `done` output, 1 bit: high for exactly one cycle, in state DONE.
- `ALUResult` output, WIDTH bits: registered result, held until the next completion.
- `Zero` output, 1 bit: registered `ALUResult == 0`, updated together with `ALUResult`.
- `illegal` output, 1 bit: registered; high with `done` when the completed op code was illegal.

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE, `ALUResult=0`, `Zero=1`, `illegal=0`, `busy=0`, `done=0`, and clears the internal shift register and counter.
- Accepting a request requires `start=1` in IDLE or DONE. This permits back-to-back issue; `start` in SHIFT is ignored and not queued.
- Non-shift op accepted: compute from the live `A`/`B`, write `ALUResult`/`Zero`/`illegal`, then go to DONE.
  - ADD and SUB wrap modulo 2^WIDTH; no overflow flag, no trap.
  - NOR is ~(A|B).
  - Illegal code gives `ALUResult=0`, `Zero=1`, `illegal=1`.
- Shift op accepted: latch `B` into the shift register, `shamt` into the counter and the direction, then go to SHIFT. `A` is ignored.
- In SHIFT, on each edge:
  - If counter ≠ 0: shift the register by 1 (SRL logical, zero fill; SLL zero fill) and decrement the counter.
  - If counter = 0: write the register to `ALUResult`, update `Zero`, clear `illegal`, and go to DONE.
- DONE with no `start`: go to IDLE. Outputs hold their values.
- Operands may change freely after the accept edge; shifts use only the latched copies.
- Asynchronous reset mid-shift abandons the operation. No `done` is produced for it.

## Timing
- Accept edge = edge E0.
- Non-shift: `done` is high in the cycle after E0; latency 1.
- Shift by n: `busy` is high for n+1 cycles after E0. `done` is high in the cycle after edge E0+n+1; latency n+2, i.e. 2 for n=0 and 33 for n=31.
- `ALUResult`, `Zero` and `illegal` change only on the edge that enters DONE, and are valid whenever `done=1`.
- `start` held high continuously: in IDLE or DONE a new op is accepted every accepting cycle, so non-shift ops give `done` every cycle.
- No combinational path from inputs to any output.

## Structure
- Package `alu_ops_pkg` holds the ALUOperation code constants (shared with the ALU control decoder), the state enum, and the WIDTH/SHW defaults.
- Sub-module `iter_shifter` holds the latched operand, counter, direction, and a `finish` pulse. `seq_alu` holds the FSM, the combinational logic/arith unit, and the result registers.

## Test plan
- Reset asserted mid-shift (SLL, shamt=20, at cycle 5) → outputs return to reset values; after release, IDLE is reached and no `done` pulse appears.
- ADD with A=0xFFFFFFFF, B=1 → `done` one cycle later; `ALUResult=0`, `Zero=1`. SUB with A=5, B=7 → `ALUResult=0xFFFFFFFE`, `Zero=0`.
- SLL with B=0x00000001, shamt=31 → `busy` for 32 cycles, `done` at latency 33, `ALUResult=0x80000000`. SRL with B=0x80000000, shamt=0 → latency 2, `ALUResult=0x80000000`.
- During SRL (shamt=4), pulse `start` with ADD and change B → ignored. Result = original B>>4, and no second `done`.
- Back-to-back ops: OR, NOR, AND with `start` held high, A=0xF0F0F0F0, B=0x0F0F0F0F → `done` on three consecutive cycles with 0xFFFFFFFF, 0x00000000, 0x00000000.
- ALUOperation=1001 → `done` with `illegal=1`, `ALUResult=0`, `Zero=1`. The next legal op clears `illegal`.
